maxnet_controller: RTL and testbench
====================================

Name: maxnet_controller

Overview:
- Sequencing FSM for the 4-neuron Maxnet datapath.
- On `start`, loads the initial activations from data memory into the neuron registers.
- Then repeatedly fires update iterations, which apply mutual inhibition plus ReLU in the datapath, until exactly one neuron stays positive.
- Reports the winner index, a valid flag and a timeout flag, and sits between the top-level testbench/host and the neuron datapath.

Parameters:
- DW, 32, width of each neuron activation (two's complement).
- MAX_ITER, 16, maximum number of update iterations before giving up.
- IW, 5, width of the iteration counter; must satisfy 2^IW > MAX_ITER.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-low (0 = reset).
- start  input  1  begin a new competition; sampled only in IDLE.
- x1  input  DW  current activation of neuron 0 from the datapath registers.
- x2  input  DW  current activation of neuron 1.
- x3  input  DW  current activation of neuron 2.
- x4  input  DW  current activation of neuron 3.
- init_en  output  1  datapath load enable: registers <= memory words 0..3.
- upd_en  output  1  datapath update enable: registers <= relu(x_i - eps*sum others).
- busy  output  1  high from LOAD through DONE inclusive.
- done  output  1  one-cycle completion pulse.
- winner  output  2  index of the surviving neuron (0..3).
- win_valid  output  1  winner is meaningful.
- timeout  output  1  MAX_ITER reached without convergence.
- iter_cnt  output  IW  update iterations performed in the current or last run.

Behaviour:
- States: IDLE, LOAD, CHECK, UPDATE, DONE. Fully synchronous except reset.
- All outputs are Moore, registered or decoded from state; no combinational path from x1..x4 or start to outputs.
- Active neuron: x_i is active iff x_i > 0 (sign bit 0 and value nonzero). Negative values count as inactive.
- nz[3:0] = active flags; pop = popcount(nz).
- IDLE:
  - busy=0, init_en=0, upd_en=0.
  - start=1 at a rising edge -> LOAD, and iter_cnt, winner, win_valid and timeout clear to 0 on that edge.
- LOAD:
  - init_en=1 for exactly one cycle -> CHECK.
  - Datapath registers hold the new values from the next edge.
- CHECK: evaluates x1..x4 in this cycle; priority order:
  - pop==1 -> DONE; winner = index of the set bit; win_valid=1.
  - pop==0 -> DONE; win_valid=0; timeout=0 (all-zero input or all extinguished).
  - iter_cnt==MAX_ITER -> DONE; timeout=1; win_valid=0; winner=0.
  - otherwise -> UPDATE.
- UPDATE:
  - upd_en=1 for exactly one cycle.
  - iter_cnt increments (saturates at MAX_ITER).
  - -> CHECK.
- DONE:
  - done=1 for one cycle -> IDLE.
  - winner, win_valid, timeout and iter_cnt hold until the next accepted start.
- Latency:
  - Start edge at cycle 0 -> init_en in cycle 1 -> CHECK in cycle 2.
  - Done pulse in cycle 3 + 2*N, where N = iterations performed.
- start while busy=1 is ignored. start held high across DONE->IDLE is accepted again at the first IDLE edge (level-sampled).
- Ties (two equal survivors the datapath never separates) terminate via timeout only.
- Reset (rst=0) at any time, including mid-UPDATE:
  - -> IDLE immediately.
  - All outputs 0: init_en, upd_en, busy, done, winner, win_valid, timeout, iter_cnt.
  - The controller does not touch memory contents.
- After reset release, the first accepted start performs a full LOAD; no state survives.

Test Plan:
- Memory {3,0,0,0}, pulse start -> init_en in cycle 1; done in cycle 3; winner=0, win_valid=1, timeout=0, iter_cnt=0; upd_en never asserted.
- Memory {4,6,8,10}, bench datapath model with eps=1/4 and ReLU -> upd_en pulses alternate with CHECK cycles; done with winner=3, win_valid=1, iter_cnt=number of upd_en pulses counted by the bench.
- Memory {0,0,0,0} -> done in cycle 3; win_valid=0, timeout=0, iter_cnt=0.
- Memory {5,5,0,0}, datapath model keeps equal survivors, MAX_ITER=16 -> 16 upd_en pulses; done with timeout=1, win_valid=0, iter_cnt=16.
- Memory {-7,2,0,0} -> negative value treated inactive; done in cycle 3; winner=1, win_valid=1.
- Assert rst=0 during the 3rd UPDATE of the {4,6,8,10} run -> all outputs 0 the same cycle. Hold start high during busy -> no restart until IDLE. After release, a new start reproduces identical results.

Source files
------------

// File: rtl/maxnet_controller_if.sv
// rtl/maxnet_controller_if.sv - host/datapath bundle for the Maxnet sequencing controller
interface maxnet_controller_if #(
  parameter int DW = 32,
  parameter int IW = 5
);
  logic          start;
  logic [DW-1:0] x1;
  logic [DW-1:0] x2;
  logic [DW-1:0] x3;
  logic [DW-1:0] x4;
  logic          init_en;
  logic          upd_en;
  logic          busy;
  logic          done;
  logic [1:0]    winner;
  logic          win_valid;
  logic          timeout;
  logic [IW-1:0] iter_cnt;

  modport master (
    output start, x1, x2, x3, x4,
    input  init_en, upd_en, busy, done, winner, win_valid, timeout, iter_cnt
  );

  modport slave (
    input  start, x1, x2, x3, x4,
    output init_en, upd_en, busy, done, winner, win_valid, timeout, iter_cnt
  );
endinterface

// File: rtl/maxnet_controller.sv
// rtl/maxnet_controller.sv - sequencing FSM that loads, iterates and judges the 4-neuron Maxnet
module maxnet_controller #(
  parameter int DW       = 32,
  parameter int MAX_ITER = 16,
  parameter int IW       = 5
) (
  input logic                clk,
  input logic                rst,
  maxnet_controller_if.slave bus
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_CHECK  = 3'd2;
  localparam logic [2:0] S_UPDATE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]    state;
  logic [3:0]    nz;
  logic [2:0]    pop;
  logic [1:0]    idx;
  logic [1:0]    winner_q;
  logic          win_valid_q;
  logic          timeout_q;
  logic [IW-1:0] iter_q;

  // Strictly positive: sign clear and not zero; negatives are treated as extinguished.
  assign nz[0] = ~bus.x1[DW-1] & (|bus.x1);
  assign nz[1] = ~bus.x2[DW-1] & (|bus.x2);
  assign nz[2] = ~bus.x3[DW-1] & (|bus.x3);
  assign nz[3] = ~bus.x4[DW-1] & (|bus.x4);

  assign pop = {2'b00, nz[0]} + {2'b00, nz[1]} + {2'b00, nz[2]} + {2'b00, nz[3]};

  always_comb begin
    idx = 2'd0;
    if (nz[1]) idx = 2'd1;
    if (nz[2]) idx = 2'd2;
    if (nz[3]) idx = 2'd3;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      winner_q    <= 2'd0;
      win_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      iter_q      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state       <= S_LOAD;
            winner_q    <= 2'd0;
            win_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            iter_q      <= '0;
          end
        end
        S_LOAD: state <= S_CHECK;
        S_CHECK: begin
          if (pop == 3'd1) begin
            state       <= S_DONE;
            winner_q    <= idx;
            win_valid_q <= 1'b1;
          end else if (pop == 3'd0) begin
            state       <= S_DONE;
            win_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
          end else if (iter_q == IW'(MAX_ITER)) begin
            state       <= S_DONE;
            timeout_q   <= 1'b1;
            win_valid_q <= 1'b0;
            winner_q    <= 2'd0;
          end else begin
            state <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          if (iter_q != IW'(MAX_ITER)) iter_q <= iter_q + 1'b1;
          state <= S_CHECK;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.init_en   = (state == S_LOAD);
  assign bus.upd_en    = (state == S_UPDATE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = (state == S_DONE);
  assign bus.winner    = winner_q;
  assign bus.win_valid = win_valid_q;
  assign bus.timeout   = timeout_q;
  assign bus.iter_cnt  = iter_q;
endmodule

// File: tb/tb_maxnet_controller.sv
// tb/tb_maxnet_controller.sv - scoreboard bench for maxnet_controller with an eps=1/4 ReLU datapath model
module tb_maxnet_controller;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic signed [31:0] mem [4];
  logic signed [31:0] xr  [4];

  typedef struct {
    int start_cyc;
    int n;
    int w;
    int wv;
    int to;
  } exp_t;
  exp_t q[$];

  maxnet_controller_if #(.DW(32), .IW(5)) bus ();

  maxnet_controller #(.DW(32), .MAX_ITER(16), .IW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus.x1 = xr[0];
  assign bus.x2 = xr[1];
  assign bus.x3 = xr[2];
  assign bus.x4 = xr[3];

  function automatic logic signed [31:0] relu(input logic signed [31:0] v);
    return (v < 0) ? 32'sd0 : v;
  endfunction

  // Datapath model: each neuron is inhibited by a quarter of the sum of the others.
  always @(posedge clk) begin
    logic signed [31:0] tot;
    tot = xr[0] + xr[1] + xr[2] + xr[3];
    if (bus.init_en) begin
      for (int i = 0; i < 4; i++) xr[i] <= mem[i];
    end else if (bus.upd_en) begin
      for (int i = 0; i < 4; i++) xr[i] <= relu(xr[i] - ((tot - xr[i]) >>> 2));
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_init_en"},   int'(bus.init_en),   0);
    chk({name, "_upd_en"},    int'(bus.upd_en),    0);
    chk({name, "_busy"},      int'(bus.busy),      0);
    chk({name, "_done"},      int'(bus.done),      0);
    chk({name, "_winner"},    int'(bus.winner),    0);
    chk({name, "_win_valid"}, int'(bus.win_valid), 0);
    chk({name, "_timeout"},   int'(bus.timeout),   0);
    chk({name, "_iter_cnt"},  int'(bus.iter_cnt),  0);
  endtask

  // Monitor: per-run pulse counts, compared against the scoreboard on every done pulse.
  int n_init = 0;
  int n_upd  = 0;
  always @(negedge clk) begin
    if (!rst) begin
      n_init = 0;
      n_upd  = 0;
    end else begin
      if (bus.init_en) n_init++;
      if (bus.upd_en)  n_upd++;
      if (bus.done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("done_cycle", cyc - e.start_cyc + 1, 3 + 2 * e.n);
          chk("winner",     int'(bus.winner),    e.w);
          chk("win_valid",  int'(bus.win_valid), e.wv);
          chk("timeout",    int'(bus.timeout),   e.to);
          chk("iter_cnt",   int'(bus.iter_cnt),  e.n);
          chk("upd_pulses", n_upd,  e.n);
          chk("init_pulses", n_init, 1);
        end
        n_init = 0;
        n_upd  = 0;
      end
    end
  end

  task automatic set_mem(input int a, input int b, input int c, input int d);
    mem[0] = a; mem[1] = b; mem[2] = c; mem[3] = d;
  endtask

  task automatic wait_idle(input int bound);
    int ok;
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk);
      #2;
      if (q.size() == 0 && !bus.busy) begin
        ok = 1;
        break;
      end
    end
    chk("wait_idle", ok, 1);
  endtask

  task automatic run(input int a, input int b, input int c, input int d,
                     input int n, input int w, input int wv, input int to);
    exp_t e;
    set_mem(a, b, c, d);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    e.start_cyc = cyc; e.n = n; e.w = w; e.wv = wv; e.to = to;
    q.push_back(e);
    wait_idle(200);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    int seen;
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem[i] = 0;
      xr[i]  = 0;
    end
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run(3, 0, 0, 0,    0, 0, 1, 0);
    run(4, 6, 8, 10,   4, 3, 1, 0);
    run(0, 0, 0, 0,    0, 0, 0, 0);
    run(5, 5, 0, 0,   16, 0, 0, 1);
    run(-7, 2, 0, 0,   0, 1, 1, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("hold_winner",    int'(bus.winner),    1);
    chk("hold_win_valid", int'(bus.win_valid), 1);
    chk("hold_done_low",  int'(bus.done),      0);

    // Reset during the third UPDATE of the {4,6,8,10} run; no scoreboard entry since it aborts.
    set_mem(4, 6, 8, 10);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    seen = 0;
    for (int i = 0; i < 100 && seen < 3; i++) begin
      @(negedge clk);
      if (bus.upd_en) seen++;
    end
    chk("third_update_seen", seen, 3);
    rst = 1'b0;
    #1;
    chk_all_zero("mid_update_rst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run(4, 6, 8, 10,   4, 3, 1, 0);

    // start held high through a whole run is re-accepted on the first IDLE edge.
    set_mem(3, 0, 0, 0);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    e.start_cyc = cyc; e.n = 0; e.w = 0; e.wv = 1; e.to = 0;
    q.push_back(e);
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1'b0;
    e.start_cyc = cyc; e.n = 0; e.w = 0; e.wv = 1; e.to = 0;
    q.push_back(e);
    wait_idle(200);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
